// File: rtl/reg_file_param.sv
// Parameterised register file with register 0 hardwired to zero and a sequential hardware clear.
// Reads are combinational (optional same-cycle forwarding when REGFILE_BYPASS_EN is defined); writes land on the next rising edge.
// No handshake: while busy is high, writes and flush are ignored and reads return zero.
module reg_file_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            reg_write,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_nxt;
    logic            wr_en, clr_en;
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_nxt;
        end
    end

    // clr_idx parks at LAST_IDX on exit; it is only reloaded on entry to CLEAR
    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_idx;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = CLEAR;
                    clr_nxt   = '0;
                end
            end
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end else begin
                    clr_nxt = clr_idx + AW'(1);
                end
            end
            default: begin
                state_nxt = CLEAR;
                clr_nxt   = '0;
            end
        endcase
    end

    assign wr_en  = !reset && (state == IDLE) && !flush && reg_write && (rd != '0);
    assign clr_en = !reset && (state == CLEAR);

    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs[clr_idx] <= '0;
        end else if (wr_en) begin
            regs[rd] <= write_data;
        end
    end

    assign busy = (state == CLEAR);

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (!busy) begin
            if (rs1 != '0) read_data1 = regs[rs1];
            if (rs2 != '0) read_data2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && (rd != '0) && (rd == rs1)) read_data1 = write_data;
            if (reg_write && (rd != '0) && (rd == rs2)) read_data2 = write_data;
`endif
        end
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port.
REQ-002 Parameter NREGS, default 32: number of registers; power of two, >= 2; AW = log2(NREGS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk only.
REQ-005 flush  input  1  runtime request to re-zero the register array; synchronous.
REQ-006 reg_write  input  1  write enable for port rd.
REQ-007 rs1  input  AW  read address, port 1.
REQ-008 rs2  input  AW  read address, port 2.
REQ-009 rd  input  AW  write address.
REQ-010 write_data  input  XLEN  data written to rd.
REQ-011 read_data1  output  XLEN  combinational read of rs1.
REQ-012 read_data2  output  XLEN  combinational read of rs2.
REQ-013 busy  output  1  high while the clear sequence runs; writes ignored, reads forced to 0.

Function
REQ-014 Two-state FSM, IDLE and CLEAR, plus an AW-bit clear index clr_idx.
REQ-015 IDLE: reg_write=1 and rd!=0 -> Registers[rd] <= write_data on the rising edge; write visible to reads from the next cycle.
REQ-016 Register 0 is hardwired: writes to rd=0 discarded; reads of address 0 return 0 in every state and mode.
REQ-017 IDLE with flush=1 -> CLEAR, clr_idx <= 0; a reg_write in the same cycle is discarded.
REQ-018 CLEAR: each cycle Registers[clr_idx] <= 0, clr_idx increments by 1; when clr_idx == NREGS-1 the final register is zeroed and the FSM returns to IDLE.
REQ-019 The clear sequence takes exactly NREGS cycles from the first CLEAR cycle; busy=1 for exactly those cycles.
REQ-020 busy = (state == CLEAR), driven from registered state.
REQ-021 While busy=1: reg_write ignored, flush ignored (no restart), read_data1 = read_data2 = 0.
REQ-022 rs1 == rs2 is legal; both ports return the same value.
REQ-023 clr_idx does not wrap past NREGS-1; it is reloaded to 0 only on entry to CLEAR.

Reset
REQ-024 reset=1 at a rising edge -> state <= CLEAR, clr_idx <= 0; no register is zeroed on that edge.
REQ-025 While reset stays high, state is held in CLEAR with clr_idx = 0 and busy = 1.
REQ-026 After reset falls, the clear sequence of REQ-018 runs; busy deasserts NREGS cycles after the first edge sampled with reset low.
REQ-027 reset asserted mid-CLEAR or mid-IDLE restarts the sequence at clr_idx = 0; reset has priority over flush and reg_write.
REQ-028 Output values while reset is held: busy = 1, read_data1 = read_data2 = 0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined -> in IDLE, when reg_write=1, rd!=0 and rd equals rs1 (or rs2), that read port returns write_data in the same cycle (write-to-read forwarding).
REQ-030 Macro REGFILE_BYPASS_EN undefined -> no forwarding; the read port returns the previously stored value until the write edge; REQ-016 and REQ-021 hold in both builds.

Verification
REQ-031 reset high 3 cycles then low -> busy=1 for the 3 reset cycles plus 32 further cycles, then 0; all 32 addresses read 0.
REQ-032 IDLE, write rd=5 data 0xDEADBEEF, next cycle rs1=5 -> read_data1=0xDEADBEEF; rd=0 data 0x12345678 then rs2=0 -> read_data2=0.
REQ-033 Registers 1..31 loaded with value = index, flush pulsed 1 cycle -> busy high exactly 32 cycles; a write to rd=7 during busy is lost; afterwards all reads return 0.
REQ-034 reset asserted at clear cycle 10 -> busy stays high, sequence restarts, busy low 32 cycles after reset falls.
REQ-035 Bypass build: reg_write=1, rd=rs1=rs2=9, write_data=0xA5A5A5A5, old value 0x1 -> both reads 0xA5A5A5A5 in the same cycle; non-bypass build -> 0x1 that cycle, 0xA5A5A5A5 next cycle.
REQ-036 Parameter sweep XLEN=64, NREGS=8: reset sequence busy for 8 cycles; write/read of 0xFFFF_0000_FFFF_0000 at rd=7 round-trips intact.
